// File: rtl/key_conditioner.sv
// Time-setting key front-end: synchronise, debounce and auto-repeat
// the hour and minute push-buttons into one-cycle step pulses.

module key_chan #(
    parameter int DEB_CYC     = 1000000,
    parameter int RPT_DLY_CYC = 25000000,
    parameter int RPT_PER_CYC = 5000000,
    parameter int KEY_ACT_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    input  logic repeat_en,
    output logic pulse,
    output logic held
);

    localparam int DW   = $clog2(DEB_CYC + 1);
    localparam int RMAX = (RPT_DLY_CYC > RPT_PER_CYC) ? RPT_DLY_CYC : RPT_PER_CYC;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DLY_CYC - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(RPT_PER_CYC - 1);
    localparam logic          REL_RAW  = (KEY_ACT_LOW != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_REPEAT
    } state_t;

    logic [1:0]    sync_q;
    logic          key_lvl;
    logic          lock;
    logic [DW-1:0] lcnt;
    logic          deb;
    logic [DW-1:0] dcnt;
    state_t        state_q;
    state_t        state_d;
    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] rcnt_d;
    logic          pulse_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{REL_RAW}};
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

    // pressed = 1 regardless of raw key polarity
    assign key_lvl = sync_q[1] ^ REL_RAW;

    // Lockout: a key held through reset must be released before it counts
    always_ff @(posedge clk) begin
        if (rst) begin
            lock <= 1'b1;
            lcnt <= '0;
        end else if (lock) begin
            if (key_lvl) begin
                lcnt <= '0;
            end else if (lcnt == DEB_LAST) begin
                lock <= 1'b0;
                lcnt <= '0;
            end else begin
                lcnt <= lcnt + 1'b1;
            end
        end else begin
            lcnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || lock) begin
            deb  <= 1'b0;
            dcnt <= '0;
        end else if (key_lvl == deb) begin
            dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
            deb  <= key_lvl;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
            pulse   <= 1'b0;
            held    <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            pulse   <= pulse_d;
            held    <= deb & ~lock;
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        if (!deb || lock) begin
            state_d = S_IDLE;
            rcnt_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_PRESS;
                    rcnt_d  = '0;
                    pulse_d = 1'b1;
                end
                S_PRESS: begin
                    if (!repeat_en) begin
                        rcnt_d = '0;
                    end else if (rcnt_q == DLY_LAST) begin
                        state_d = S_REPEAT;
                        rcnt_d  = '0;
                        pulse_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                S_REPEAT: begin
                    // dropping repeat_en re-arms the long initial delay
                    if (!repeat_en) begin
                        state_d = S_PRESS;
                        rcnt_d  = '0;
                    end else if (rcnt_q == PER_LAST) begin
                        rcnt_d  = '0;
                        pulse_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

endmodule

module key_conditioner #(
    parameter int DEB_CYC     = 1000000,
    parameter int RPT_DLY_CYC = 25000000,
    parameter int RPT_PER_CYC = 5000000,
    parameter int KEY_ACT_LOW = 1
) (
    input  logic clk_50M,
    input  logic rst,
    input  logic AH_key,
    input  logic AM_key,
    input  logic repeat_en,
    output logic ah_pulse,
    output logic am_pulse,
    output logic ah_held,
    output logic am_held
);

    key_chan #(
        .DEB_CYC    (DEB_CYC),
        .RPT_DLY_CYC(RPT_DLY_CYC),
        .RPT_PER_CYC(RPT_PER_CYC),
        .KEY_ACT_LOW(KEY_ACT_LOW)
    ) u_hour (
        .clk      (clk_50M),
        .rst      (rst),
        .key_raw  (AH_key),
        .repeat_en(repeat_en),
        .pulse    (ah_pulse),
        .held     (ah_held)
    );

    key_chan #(
        .DEB_CYC    (DEB_CYC),
        .RPT_DLY_CYC(RPT_DLY_CYC),
        .RPT_PER_CYC(RPT_PER_CYC),
        .KEY_ACT_LOW(KEY_ACT_LOW)
    ) u_min (
        .clk      (clk_50M),
        .rst      (rst),
        .key_raw  (AM_key),
        .repeat_en(repeat_en),
        .pulse    (am_pulse),
        .held     (am_held)
    );

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timings.

module tb_key_conditioner;

    logic clk_50M;
    logic rst;
    logic AH_key;
    logic AM_key;
    logic repeat_en;
    logic ah_pulse;
    logic am_pulse;
    logic ah_held;
    logic am_held;

    int n_chk;
    int n_fail;

    key_conditioner #(
        .DEB_CYC    (4),
        .RPT_DLY_CYC(20),
        .RPT_PER_CYC(8),
        .KEY_ACT_LOW(1)
    ) dut (
        .clk_50M  (clk_50M),
        .rst      (rst),
        .AH_key   (AH_key),
        .AM_key   (AM_key),
        .repeat_en(repeat_en),
        .ah_pulse (ah_pulse),
        .am_pulse (am_pulse),
        .ah_held  (ah_held),
        .am_held  (am_held)
    );

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic idle(input int n);
        AH_key = 1'b1;
        AM_key = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        AH_key = 1'b1;
        AM_key = 1'b1;
        repeat_en = 1'b0;
        tick();
        tick();
        n_chk++;
        if ({ah_pulse, am_pulse, ah_held, am_held} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0000",
                     {ah_pulse, am_pulse, ah_held, am_held});
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_chk++;
        if ({ah_pulse, am_pulse, ah_held, am_held} !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b want 0000",
                     {ah_pulse, am_pulse, ah_held, am_held});
        end
    endtask

    task automatic test_clean_press();
        logic ep;
        logic eh;
        repeat_en = 1'b0;
        AH_key = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            ep = (i == 7);
            eh = (i >= 7);
            n_chk++;
            if (ah_pulse !== ep) begin
                n_fail++;
                $display("FAIL press_pulse t%0d: got %b want %b", i, ah_pulse, ep);
            end
            n_chk++;
            if (ah_held !== eh) begin
                n_fail++;
                $display("FAIL press_held t%0d: got %b want %b", i, ah_held, eh);
            end
            n_chk++;
            if (am_pulse !== 1'b0 || am_held !== 1'b0) begin
                n_fail++;
                $display("FAIL press_am_quiet t%0d: got %b%b want 00",
                         i, am_pulse, am_held);
            end
        end
        idle(12);
        n_chk++;
        if (ah_held !== 1'b0) begin
            n_fail++;
            $display("FAIL press_release: got %b want 0", ah_held);
        end
    endtask

    task automatic test_bounce();
        logic ep;
        repeat_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            AH_key = k[0];
            for (int j = 0; j < 2; j++) begin
                tick();
                n_chk++;
                if (ah_pulse !== 1'b0 || ah_held !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce_quiet k%0d: got %b%b want 00",
                             k, ah_pulse, ah_held);
                end
            end
        end
        AH_key = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            ep = (i == 7);
            n_chk++;
            if (ah_pulse !== ep) begin
                n_fail++;
                $display("FAIL bounce_settle t%0d: got %b want %b", i, ah_pulse, ep);
            end
        end
        idle(12);
    endtask

    task automatic test_repeat();
        logic ep;
        logic eh;
        repeat_en = 1'b1;
        AH_key = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            ep = (i == 7) || (i == 27) || (i == 35) ||
                 (i == 43) || (i == 51) || (i == 59);
            n_chk++;
            if (ah_pulse !== ep) begin
                n_fail++;
                $display("FAIL repeat_pulse t%0d: got %b want %b", i, ah_pulse, ep);
            end
        end
        AH_key = 1'b1;
        for (int i = 61; i <= 72; i++) begin
            tick();
            eh = (i < 67);
            n_chk++;
            if (ah_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL release_no_pulse t%0d: got %b want 0", i, ah_pulse);
            end
            n_chk++;
            if (ah_held !== eh) begin
                n_fail++;
                $display("FAIL release_held t%0d: got %b want %b", i, ah_held, eh);
            end
        end
        repeat_en = 1'b0;
        idle(6);
    endtask

    task automatic test_repeat_gate();
        logic ep;
        repeat_en = 1'b0;
        AH_key = 1'b0;
        for (int i = 1; i <= 66; i++) begin
            tick();
            ep = (i == 7) || (i == 57) || (i == 65);
            n_chk++;
            if (ah_pulse !== ep) begin
                n_fail++;
                $display("FAIL gate_pulse t%0d: got %b want %b", i, ah_pulse, ep);
            end
            if (i == 37) repeat_en = 1'b1;
        end
        repeat_en = 1'b0;
        idle(12);
    endtask

    task automatic test_lockout();
        logic ep;
        repeat_en = 1'b0;
        AM_key = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n_chk++;
            if (am_pulse !== 1'b0 || am_held !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_hold t%0d: got %b%b want 00",
                         i, am_pulse, am_held);
            end
        end
        AM_key = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_chk++;
            if (am_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_release t%0d: got %b want 0", i, am_pulse);
            end
        end
        AM_key = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            ep = (i == 7);
            n_chk++;
            if (am_pulse !== ep) begin
                n_fail++;
                $display("FAIL lock_repress t%0d: got %b want %b", i, am_pulse, ep);
            end
        end
        idle(12);
    endtask

    task automatic test_dual_and_reset();
        logic ep;
        repeat_en = 1'b1;
        AH_key = 1'b0;
        AM_key = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            ep = (i == 7) || (i == 27);
            n_chk++;
            if (ah_pulse !== ep || am_pulse !== ep) begin
                n_fail++;
                $display("FAIL dual_pulse t%0d: got %b%b want %b%b",
                         i, ah_pulse, am_pulse, ep, ep);
            end
        end
        n_chk++;
        if (ah_held !== 1'b1 || am_held !== 1'b1) begin
            n_fail++;
            $display("FAIL dual_held: got %b%b want 11", ah_held, am_held);
        end
        rst = 1'b1;
        tick();
        n_chk++;
        if ({ah_pulse, am_pulse, ah_held, am_held} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_repeat_reset: got %b want 0000",
                     {ah_pulse, am_pulse, ah_held, am_held});
        end
        tick();
        rst = 1'b0;
        repeat_en = 1'b0;
        idle(12);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        AH_key = 1'b1;
        AM_key = 1'b1;
        repeat_en = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_repeat_gate();
        test_lockout();
        test_dual_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Upstream front-end for the two time-setting push-buttons (AH_key = hour, AM_key = minute).
- Converts raw, bouncing, asynchronous, active-low key inputs into clean one-cycle pulses in the clk_50M domain.
- The hour/minute setting logic of the timekeeping and alarm stages consumes these pulses in place of the raw keys.
- Adds hold-to-auto-repeat so a held key steps the value continuously.

Parameters:
- DEB_CYC, 1000000: consecutive stable cycles needed to accept a level change (20 ms at 50 MHz).
- RPT_DLY_CYC, 25000000: cycles from the press pulse to the first repeat pulse (500 ms).
- RPT_PER_CYC, 5000000: cycles between later repeat pulses (100 ms).
- KEY_ACT_LOW, 1: 1 = raw keys read 0 when pressed; 0 = read 1 when pressed.

Ports:
- clk_50M  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- AH_key  input  1  raw hour key; asynchronous, bouncing.
- AM_key  input  1  raw minute key; asynchronous, bouncing.
- repeat_en  input  1  1 = auto-repeat allowed (driven high in set modes).
- ah_pulse  output  1  one-cycle step pulse for the hour key.
- am_pulse  output  1  one-cycle step pulse for the minute key.
- ah_held  output  1  debounced pressed level, hour key.
- am_held  output  1  debounced pressed level, minute key.

Behaviour:
- One channel per key, identical and fully independent. Simultaneous activity on both keys yields independent pulses, which may land in the same cycle.
- Input conditioning:
  - Raw key passes a 2-FF synchroniser, then is polarity-normalised (pressed = 1).
  - Synchroniser flops reset to the released value.
- Debounce:
  - Counter dcnt, width clog2(DEB_CYC+1), runs while synced level != held.
  - dcnt is cleared on any cycle where synced level == held.
  - On the cycle dcnt reaches DEB_CYC-1 with the mismatch still present: held <= synced level, dcnt <= 0.
  - Glitches shorter than DEB_CYC cycles never change held.
- Latency: a clean press stable from edge t gives held=1 and the press pulse registered at edge t+2+DEB_CYC.
- Per-channel state machine:
  - IDLE: held=0. On held rising → PRESS (emit pulse, clear rcnt).
  - PRESS: rcnt counts each cycle when repeat_en=1. At rcnt==RPT_DLY_CYC-1 → emit pulse, clear rcnt, go to REPEAT.
  - REPEAT: at rcnt==RPT_PER_CYC-1 → emit pulse, clear rcnt, stay in REPEAT.
  - Any state: held falling → IDLE, rcnt=0, no pulse on release.
- repeat_en handling:
  - repeat_en=0 in PRESS or REPEAT: rcnt held at 0, no repeat pulses, and REPEAT falls back to PRESS.
  - Re-asserting repeat_en while the key is held restarts the full RPT_DLY_CYC delay.
  - The initial press pulse is emitted regardless of repeat_en.
- Pulse rules:
  - Each pulse is exactly 1 cycle.
  - No two pulses of one channel occur closer than min(RPT_PER_CYC, DEB_CYC) cycles.
- Reset:
  - While rst=1: all outputs 0, held=0, counters 0, FSMs IDLE, lockout flag lock=1.
  - The lockout flag is per channel. While lock=1, held and pulses are forced 0.
  - lock clears only after the synced level has been released for DEB_CYC consecutive cycles. A key held through reset release therefore produces no pulse until it is released and pressed again.
  - Reset asserted mid-hold or mid-debounce aborts immediately; the next cycle shows all outputs 0.
- Counter sizing:
  - rcnt width is clog2(max(RPT_DLY_CYC, RPT_PER_CYC)+1).
  - Counters never wrap: they saturate or clear as described.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
All scenarios use DEB_CYC=4, RPT_DLY_CYC=20, RPT_PER_CYC=8, KEY_ACT_LOW=1.
- Reset with keys released (1) for 10 cycles, then drive AH_key=0 cleanly at edge t → ah_held=1 and ah_pulse=1 for exactly one cycle at edge t+6; am_pulse stays 0.
- Bounce: AH_key toggles every 2 cycles for 20 cycles, then settles at 0 → no pulse during bouncing; exactly one ah_pulse 6 cycles after settling.
- Hold with repeat_en=1 for 60 cycles after the press pulse at cycle P → ah_pulse at P, P+20, P+28, P+36, P+44, P+52; release → ah_held=0 6 cycles later, no pulse.
- Hold with repeat_en=0, then raise repeat_en at P+30 → only the pulse at P until P+50, then pulses at P+50, P+58, ...
- Hold AM_key=0 through reset deassertion for 40 cycles → am_pulse and am_held stay 0. Release 5 cycles, press again → one am_pulse after 6 cycles.
- Press both keys at the same edge → ah_pulse and am_pulse asserted in the same cycle, once each. Assert rst mid-repeat → all outputs 0 on the next cycle.
